// File: rtl/cla_seq_adder_if.sv
// ----------------------------------------------------------------------------
// cla_seq_adder_if
//   Request/response bundle for cla_seq_adder.
//   Request  : in_valid/in_ready handshake carrying a, b, ci, sub.
//   Response : out_valid/out_ready handshake carrying sum, co, zero
//              (and ovf when CLA_SEQ_OVF_EN is defined).
//   Modports : master = issuer/consumer side, slave = adder side.
// ----------------------------------------------------------------------------
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             zero;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, sum, co, zero, ovf);
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, sum, co, zero, ovf);
`else
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, sum, co, zero);
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, sum, co, zero);
`endif
endinterface

// File: rtl/cla_seq_adder.sv
// ----------------------------------------------------------------------------
// cla_seq_adder
//   Multi-cycle WIDTH-bit adder/subtractor. One 8-bit carry-lookahead slice is
//   reused every cycle, LSB slice first, with the carry registered between
//   cycles. Result is presented with a valid/ready handshake.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - cla_seq_adder_if.slave
//            in_valid/in_ready, a, b, ci, sub   (request)
//            out_valid/out_ready, sum, co, zero (response)
//            ovf                                (only with CLA_SEQ_OVF_EN)
//
//   Parameters:
//     WIDTH - operand width, multiple of 8, >= 8
//     SLICE - bits per cycle, fixed at 8 (matches cla8)
//
//   Optional feature macro: CLA_SEQ_OVF_EN adds the signed-overflow flag ovf.
// ----------------------------------------------------------------------------

// 8-bit carry-lookahead slice. Every carry is formed directly as a
// sum-of-products of generate/propagate terms and cin, not rippled.
module cla8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c7,    // carry into bit 7
    output logic       cout   // carry out of bit 7
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       t;
    logic       pp;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        t    = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & cin);
        end
        s    = p ^ c[7:0];
        c7   = c[7];
        cout = c[8];
    end
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic           clk,
    input  logic           rst,
    cla_seq_adder_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    // At least one counter bit so WIDTH == 8 still has a legal vector.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtract
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             zero_q;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf_q;
`endif

    logic             in_ready_c;
    logic             out_valid_c;
    logic             last;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c7_sl;
    logic             cout_sl;
    logic [WIDTH-1:0] sum_nx;

    assign last = (cnt_q == CW'(N - 1));

    // ---------------- FSM next-state / handshake outputs ----------------
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Not ready while reset is being applied, even though the state is IDLE.
    assign bus.in_ready  = in_ready_c & ~rst;
    assign bus.out_valid = out_valid_c;

    // ---------------- slice select / write-back ----------------
    always_comb begin
        a_sl   = '0;
        b_sl   = '0;
        sum_nx = sum_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
                sum_nx[k*SLICE +: SLICE] = s_sl;
            end
        end
    end

    cla8 u_slice (
        .x    (a_sl),
        .y    (b_sl),
        .cin  (carry_q),
        .s    (s_sl),
        .c7   (c7_sl),
        .cout (cout_sl)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1: fold the inversion and the +1
                        // into the latched operand and initial carry.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.ci;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_nx;
                    carry_q <= cout_sl;
                    if (last) begin
                        co_q   <= cout_sl;
                        zero_q <= (sum_nx == '0);
`ifdef CLA_SEQ_OVF_EN
                        ovf_q  <= c7_sl ^ cout_sl;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.zero = zero_q;
`ifdef CLA_SEQ_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
